fft_bitrev_reorder: RTL

//  Output-side companion of the 1024-point pipelined FFT. Accepts the FFT's

---
 rtl/fft_bitrev_reorder.sv | 65 ++++++
 1 files changed

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer that turns a bit-reversed FFT output
// stream into natural bin order, one frame per bank.
module fft_bitrev_reorder #(
  parameter int LOG2N = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          i_strb,
  input  logic [DW-1:0] i_data,
  output logic          o_strb,
  output logic [DW-1:0] o_data,
  output logic          o_sof
);
  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_nx;
  logic [LOG2N-1:0] wcnt, rcnt;
  logic wbank, rbank, wlast, rlast, re;
  logic [1:0] bank_full, set_v, clr_v;
  logic [DW-1:0] mem [2**(LOG2N+1)];
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction
  assign wlast = i_strb && &wcnt;
  assign rlast = re && &rcnt;
  assign set_v = {wlast && wbank, wlast && !wbank};
  assign clr_v = {rlast && rbank, rlast && !rbank};
  always_ff @(posedge clk)
    if (i_strb) mem[{wbank, bitrev(wcnt)}] <= i_data;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      wcnt      <= '0;
      wbank     <= 1'b0;
      rcnt      <= '0;
      rbank     <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      assert (!(wlast && bank_full[wbank]));
      if (i_strb) wcnt <= wcnt + 1'b1;
      wbank     <= wbank ^ wlast;
      if (re) rcnt <= rcnt + 1'b1;
      rbank     <= rbank ^ rlast;
      bank_full <= (bank_full & ~clr_v) | set_v;
    end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) state <= IDLE;
    else state <= state_nx;
  // Chain straight into the other bank if it is full or completes this very cycle
  always_comb
    state_nx = (state == IDLE) ? (bank_full[rbank] ? READ : IDLE) :
               (!rlast || bank_full[~rbank] || (wlast && wbank != rbank)) ? READ : IDLE;
  always_comb re = (state == READ);
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      o_strb <= 1'b0;
      o_sof  <= 1'b0;
      o_data <= '0;
    end else begin
      o_strb <= re;
      o_sof  <= re && rcnt == '0;
      if (re) o_data <= mem[{rbank, rcnt}];
    end
endmodule
